// File: rtl/noc_pkg.sv
// noc_pkg: shared Spidergon NoC definitions.
//   - direction codes used by the router and as output-port indices
//   - input-port index constants
//   - default ring size (a smaller ring for formal runs)
package noc_pkg;

  localparam int DIRECTION_WIDTH = 2;
  localparam int NUM_PORTS       = 4;

  typedef enum logic [DIRECTION_WIDTH-1:0] {
    ANTI_CLOCKWISE = 2'd0,
    CLOCKWISE      = 2'd1,
    ACROSS         = 2'd2,
    STOP           = 2'd3
  } direction_e;

  // Input port indices
  localparam int IN_LOCAL  = 0;
  localparam int IN_ACW    = 1;
  localparam int IN_CW     = 2;
  localparam int IN_ACROSS = 3;

`ifdef FORMAL
  localparam int DEFAULT_NUM_OF_NODES = 8;
`else
  localparam int DEFAULT_NUM_OF_NODES = 32;
`endif

endpackage

// File: rtl/router.sv
// router: Spidergon shortest-path direction for one flit.
// Ports:
//   current_node  in   this node's ID
//   dest_node     in   destination node of the flit
//   direction     out  ANTI_CLOCKWISE / CLOCKWISE / ACROSS / STOP
module router
  import noc_pkg::*;
#(
  parameter  int NUM_OF_NODES = DEFAULT_NUM_OF_NODES,
  localparam int NODE_W       = $clog2(NUM_OF_NODES)
) (
  input  logic [NODE_W-1:0]          current_node,
  input  logic [NODE_W-1:0]          dest_node,
  output logic [DIRECTION_WIDTH-1:0] direction
);

  localparam logic [NODE_W+1:0] N_X1 = (NODE_W+2)'(NUM_OF_NODES);
  localparam logic [NODE_W+1:0] N_X3 = (NODE_W+2)'(3 * NUM_OF_NODES);

  // Ring size is a power of two, so the subtraction wraps modulo N for free.
  logic [NODE_W-1:0] rel_ad;
  logic [NODE_W+1:0] rel_x4;

  assign rel_ad = dest_node - current_node;
  // Comparing 4*RelAd against N and 3N avoids fractional thresholds.
  assign rel_x4 = {rel_ad, 2'b00};

  always_comb begin
    direction = ACROSS;
    if (rel_x4 == '0) begin
      direction = STOP;
    end else if (rel_x4 <= N_X1) begin
      direction = CLOCKWISE;
    end else if (rel_x4 >= N_X3) begin
      direction = ANTI_CLOCKWISE;
    end
  end

endmodule

// File: rtl/spidergon_switch_allocator_rr_arbiter.sv
// spidergon_rr_arbiter: 4-requester round-robin arbiter for one output port.
// Ports:
//   clk, reset  in   clock, synchronous active-high reset
//   req         in   request per input
//   en          in   output slot can accept a flit this cycle
//   gnt         out  one-hot grant (all zero when disabled or idle)
module spidergon_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt
);

  // Last granted input; reset to 3 so input 0 is searched first.
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] idx;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    // Search ptr+1, ptr+2, ptr+3, ptr; the first requester wins.
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (en && req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
        ptr_d    = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spidergon_switch_allocator.sv
// spidergon_switch_allocator: per-node 4x4 switch allocator for the Spidergon NoC.
// Ports:
//   clk, reset    in   clock, synchronous active-high reset
//   current_node  in   static node ID
//   in_valid      in   per input: 0 local, 1 from ACW, 2 from CW, 3 from across
//   in_flit       in   input i at [i*FLIT_W +: FLIT_W], dest in the top NODE_W bits
//   in_ready      out  input i granted this cycle
//   out_valid     out  per direction code: 0 ACW, 1 CW, 2 ACROSS, 3 eject
//   out_flit      out  registered flit per output, same slicing as in_flit
//   out_ready     in   downstream accepts the held flit
module spidergon_switch_allocator
  import noc_pkg::*;
#(
  parameter  int NUM_OF_NODES  = DEFAULT_NUM_OF_NODES,
  parameter  int PAYLOAD_WIDTH = 16,
  localparam int NODE_W        = $clog2(NUM_OF_NODES),
  localparam int FLIT_W        = NODE_W + PAYLOAD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NODE_W-1:0]     current_node,
  input  logic [3:0]            in_valid,
  input  logic [4*FLIT_W-1:0]   in_flit,
  output logic [3:0]            in_ready,
  output logic [3:0]            out_valid,
  output logic [4*FLIT_W-1:0]   out_flit,
  input  logic [3:0]            out_ready
);

  logic [3:0][FLIT_W-1:0]          in_flit_a;
  logic [3:0][DIRECTION_WIDTH-1:0] dir;
  logic [3:0][3:0]                 req;   // req[o][i]
  logic [3:0][3:0]                 gnt;   // gnt[o][i], one-hot per output
  logic [3:0]                      arb_en;

  logic [3:0]             out_valid_q, out_valid_d;
  logic [3:0][FLIT_W-1:0] out_flit_q,  out_flit_d;

  assign in_flit_a = in_flit;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_route
    router #(.NUM_OF_NODES(NUM_OF_NODES)) u_router (
      .current_node (current_node),
      .dest_node    (in_flit_a[i][FLIT_W-1 -: NODE_W]),
      .direction    (dir[i])
    );
  end

  // Each input requests only the output its router picked.
  always_comb begin
    req = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = in_valid[i] && (dir[i] == DIRECTION_WIDTH'(o));
      end
    end
  end

  // A slot is free when empty or when its occupant leaves this cycle.
  // Reset blocks all grants so in_ready stays low while reset is high.
  assign arb_en = (~out_valid_q | out_ready) & {4{~reset}};

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    spidergon_rr_arbiter u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (req[o]),
      .en    (arb_en[o]),
      .gnt   (gnt[o])
    );
  end

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      in_ready = in_ready | gnt[o];
    end
  end

  // Grant loads the slot (replacing a departing flit with no bubble);
  // otherwise a ready downstream empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (gnt[o] != '0) begin
        out_valid_d[o] = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (gnt[o][i]) begin
            out_flit_d[o] = in_flit_a[i];
          end
        end
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= '0;
      out_flit_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

endmodule

// File: tb/tb_spidergon_switch_allocator.sv
// Testbench for spidergon_switch_allocator with an 8-node ring.
module tb_spidergon_switch_allocator;

  localparam int N      = 8;
  localparam int NODE_W = 3;
  localparam int FLIT_W = NODE_W + 16;

  logic                clk;
  logic                reset;
  logic [NODE_W-1:0]   current_node;
  logic [3:0]          in_valid;
  logic [4*FLIT_W-1:0] in_flit;
  logic [3:0]          in_ready;
  logic [3:0]          out_valid;
  logic [4*FLIT_W-1:0] out_flit;
  logic [3:0]          out_ready;

  int n_cmp;
  int n_mis;

  typedef struct packed {
    logic                   rst;
    logic [NODE_W-1:0]      cur;
    logic [3:0]             iv;
    logic [3:0][FLIT_W-1:0] f;
    logic [3:0]             ordy;
    logic [3:0]             erdy;
    logic [3:0]             evld;
    logic [3:0][FLIT_W-1:0] ef;
  } cyc_t;

  typedef struct packed {
    logic [3:0]             vld;
    logic [3:0][FLIT_W-1:0] flit;
  } exp_t;

  exp_t exp_q[$];

  spidergon_switch_allocator #(.NUM_OF_NODES(N), .PAYLOAD_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .current_node (current_node),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FLIT_W-1:0] mk(input int d, input logic [15:0] p);
    return {NODE_W'(d), p};
  endfunction

  task automatic test_reset();
    reset = 1'b1; current_node = '0; out_ready = 4'hF;
    in_valid = 4'b0001; in_flit = '0; in_flit[FLIT_W-1:0] = mk(2, 16'h1234);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 4'b0000) begin
        n_mis++; $display("FAIL reset in_ready cyc %0d: got %b want 0000", k, in_ready);
      end
      n_cmp++;
      if (out_valid !== 4'b0000) begin
        n_mis++; $display("FAIL reset out_valid cyc %0d: got %b want 0000", k, out_valid);
      end
      n_cmp++;
      if (out_flit !== '0) begin
        n_mis++; $display("FAIL reset out_flit cyc %0d: got %h want 0", k, out_flit);
      end
    end
    reset = 1'b0; in_valid = '0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 4'b0000) begin
      n_mis++; $display("FAIL reset idle out_valid: got %b want 0000", out_valid);
    end
  endtask

  task automatic test_single();
    cyc_t c[2]; exp_t e;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    c[0].iv = 4'b0001; c[0].f[0] = mk(2, 16'hABCD);
    c[0].erdy = 4'b0001; c[0].evld = 4'b0010; c[0].ef[1] = {3'd2, 16'hABCD};
    for (int k = 0; k < 2; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL single in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL single out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL single out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    cyc_t c[5]; exp_t e;
    logic [3:0] order [4];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b0001;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    for (int k = 0; k < 4; k++) begin
      c[k].iv = 4'b0111;
      for (int i = 0; i < 3; i++) c[k].f[i] = mk(4, 16'h2000 + 16'(i));
      c[k].erdy = order[k];
      c[k].evld = 4'b0100;
    end
    c[0].ef[2] = mk(4, 16'h2000); c[1].ef[2] = mk(4, 16'h2001);
    c[2].ef[2] = mk(4, 16'h2002); c[3].ef[2] = mk(4, 16'h2000);
    for (int k = 0; k < 5; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL rr in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL rr out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL rr out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
  endtask

  // Two consecutive cycles with four disjoint destinations each.
  task automatic test_back_to_back();
    cyc_t c[3]; exp_t e;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    c[0].iv = 4'hF; c[0].erdy = 4'hF; c[0].evld = 4'hF;
    c[0].f[0] = mk(0, 16'h1000); c[0].f[1] = mk(1, 16'h1111);
    c[0].f[2] = mk(4, 16'h2222); c[0].f[3] = mk(7, 16'h3333);
    c[0].ef[3] = mk(0, 16'h1000); c[0].ef[1] = mk(1, 16'h1111);
    c[0].ef[2] = mk(4, 16'h2222); c[0].ef[0] = mk(7, 16'h3333);
    c[1].iv = 4'hF; c[1].erdy = 4'hF; c[1].evld = 4'hF;
    c[1].f[0] = mk(7, 16'h4000); c[1].f[1] = mk(0, 16'h4111);
    c[1].f[2] = mk(1, 16'h4222); c[1].f[3] = mk(4, 16'h4333);
    c[1].ef[0] = mk(7, 16'h4000); c[1].ef[3] = mk(0, 16'h4111);
    c[1].ef[1] = mk(1, 16'h4222); c[1].ef[2] = mk(4, 16'h4333);
    for (int k = 0; k < 3; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL b2b in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL b2b out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL b2b out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    cyc_t c[8]; exp_t e;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    c[0].iv = 4'b0001; c[0].f[0] = mk(1, 16'h0B01);
    c[0].erdy = 4'b0001; c[0].evld = 4'b0010; c[0].ef[1] = mk(1, 16'h0B01);
    for (int k = 1; k <= 5; k++) begin
      c[k].iv = 4'b0010; c[k].f[1] = mk(1, 16'h0B02); c[k].ordy = 4'b1101;
      c[k].erdy = 4'b0000; c[k].evld = 4'b0010; c[k].ef[1] = mk(1, 16'h0B01);
    end
    // An unrelated output keeps flowing while CW is stalled.
    c[1].iv = 4'b1010; c[1].f[3] = mk(4, 16'h0B44); c[1].erdy = 4'b1000;
    c[1].evld = 4'b0110; c[1].ef[2] = mk(4, 16'h0B44);
    c[6].iv = 4'b0010; c[6].f[1] = mk(1, 16'h0B02);
    c[6].erdy = 4'b0010; c[6].evld = 4'b0010; c[6].ef[1] = mk(1, 16'h0B02);
    for (int k = 0; k < 8; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL bp in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL bp out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL bp out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    cyc_t c[4]; exp_t e;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    c[0].cur = 3'd6; c[0].iv = 4'b0001; c[0].f[0] = mk(1, 16'h0601);
    c[0].erdy = 4'b0001; c[0].evld = 4'b0100; c[0].ef[2] = mk(1, 16'h0601);
    c[1].cur = 3'd5; c[1].iv = 4'b0001; c[1].f[0] = mk(4, 16'h0504);
    c[1].erdy = 4'b0001; c[1].evld = 4'b0001; c[1].ef[0] = mk(4, 16'h0504);
    c[2].cur = 3'd7; c[2].iv = 4'b0001; c[2].f[0] = mk(0, 16'h0700);
    c[2].erdy = 4'b0001; c[2].evld = 4'b0010; c[2].ef[1] = mk(0, 16'h0700);
    c[3].cur = 3'd7;
    for (int k = 0; k < 4; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL wrap in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL wrap out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL wrap out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c[5]; exp_t e;
    foreach (c[k]) begin c[k] = '0; c[k].ordy = 4'hF; end
    c[0].iv = 4'b0011; c[0].f[0] = mk(7, 16'h5A00); c[0].f[1] = mk(4, 16'h5A01);
    c[0].ordy = 4'b0000; c[0].erdy = 4'b0011; c[0].evld = 4'b0101;
    c[0].ef[0] = mk(7, 16'h5A00); c[0].ef[2] = mk(4, 16'h5A01);
    c[1] = c[0]; c[1].rst = 1'b1; c[1].erdy = 4'b0000; c[1].evld = 4'b0000; c[1].ef = '0;
    c[2].iv = 4'b0111;
    for (int i = 0; i < 3; i++) c[2].f[i] = mk(4, 16'h5B00 + 16'(i));
    c[2].erdy = 4'b0001; c[2].evld = 4'b0100; c[2].ef[2] = mk(4, 16'h5B00);
    c[3] = c[2]; c[3].iv = 4'b0110;
    c[3].erdy = 4'b0010; c[3].ef[2] = mk(4, 16'h5B01);
    for (int k = 0; k < 5; k++) begin
      reset = c[k].rst; current_node = c[k].cur; in_valid = c[k].iv;
      in_flit = c[k].f; out_ready = c[k].ordy;
      #1;
      n_cmp++;
      if (in_ready !== c[k].erdy) begin
        n_mis++; $display("FAIL rstmid in_ready cyc %0d: got %b want %b", k, in_ready, c[k].erdy);
      end
      e.vld = c[k].evld; e.flit = c[k].ef; exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== e.vld) begin
        n_mis++; $display("FAIL rstmid out_valid cyc %0d: got %b want %b", k, out_valid, e.vld);
      end
      for (int o = 0; o < 4; o++) if (e.vld[o]) begin
        n_cmp++;
        if (out_flit[o*FLIT_W +: FLIT_W] !== e.flit[o]) begin
          n_mis++; $display("FAIL rstmid out_flit[%0d] cyc %0d: got %h want %h", o, k, out_flit[o*FLIT_W +: FLIT_W], e.flit[o]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    current_node = '0;
    in_valid = '0;
    in_flit = '0;
    out_ready = 4'hF;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
